// File: rtl/led_pkg.sv
// Shared constants and types for the 8x8 LED matrix display blocks.
package led_pkg;

  localparam int unsigned LED_ROWS = 8;
  localparam int unsigned LED_COLS = 8;
  localparam int unsigned FRAME_W  = LED_ROWS * LED_COLS;
  localparam int unsigned ROW_W    = $clog2(LED_ROWS);

  // Row 1 (top) sits in the MSBs; row 8 (bottom) ends at bit 0.
  localparam int unsigned ROW_TOP_MSB = FRAME_W - 1;
  localparam int unsigned ROW_BOT_LSB = 0;

  typedef enum logic {
    OWN_A = 1'b0,
    OWN_B = 1'b1
  } owner_e;

  typedef enum logic {
    SH_EMPTY = 1'b0,
    SH_FULL  = 1'b1
  } sh_state_e;

  // MSB index of a zero-based row inside a packed frame.
  function automatic int unsigned row_msb(input int unsigned row);
    return ROW_TOP_MSB - (row * LED_COLS);
  endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Row-advance prescaler and row counter; flags the last-row pulse of each scan.
module led_tick_gen
  import led_pkg::*;
#(
  parameter int unsigned TICK_DIV = 1000
) (
  input  logic             clk,
  input  logic             rst,
  output logic             timePulseOut,
  output logic [ROW_W-1:0] rowCnt,
  output logic             boundary
);

  localparam int unsigned      PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(LED_ROWS - 1);

  logic [PRE_W-1:0] presc_q, presc_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic             pulse_q, pulse_d;
  logic             bnd_q, bnd_d;

  // The row count only moves after a pulse, so it is stable across the pulse cycle.
  always_comb begin
    presc_d = (presc_q == PRE_LAST) ? '0 : presc_q + PRE_W'(1);
    pulse_d = (presc_q == PRE_LAST);
    bnd_d   = pulse_d && (row_q == ROW_LAST);
    row_d   = pulse_q ? row_q + ROW_W'(1) : row_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= '0;
      row_q   <= '0;
      pulse_q <= 1'b0;
      bnd_q   <= 1'b0;
    end else begin
      presc_q <= presc_d;
      row_q   <= row_d;
      pulse_q <= pulse_d;
      bnd_q   <= bnd_d;
    end
  end

  assign timePulseOut = pulse_q;
  assign rowCnt       = row_q;
  assign boundary     = bnd_q;

endmodule

// File: rtl/led_frame_scheduler.sv
// Round-robin arbiter between two frame producers with a tear-free shadow buffer
// that swaps onto the display only at a full-scan boundary.
module led_frame_scheduler
  import led_pkg::*;
#(
  parameter int unsigned TICK_DIV = 1000,
  parameter int unsigned ROWS     = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               reqA_valid,
  input  logic [FRAME_W-1:0] reqA_frame,
  output logic               reqA_ready,
  input  logic               reqB_valid,
  input  logic [FRAME_W-1:0] reqB_frame,
  output logic               reqB_ready,
  output logic [FRAME_W-1:0] matrixOut,
  output logic               timePulseOut,
  output logic               frameDone,
  output logic               ownerOut
);

  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);

  sh_state_e          state_q, state_d;
  logic [FRAME_W-1:0] shadow_q, shadow_d;
  logic [FRAME_W-1:0] matrix_q, matrix_d;
  owner_e             shadow_own_q, shadow_own_d;
  owner_e             owner_q, owner_d;
  owner_e             last_q, last_d;
  owner_e             grant;
  logic               done_q, done_d;
  logic               boundary;
  logic               frame_end;
  logic               accept;
  logic [ROW_W-1:0]   row_cnt;

  led_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .clk         (clk),
    .rst         (rst),
    .timePulseOut(timePulseOut),
    .rowCnt      (row_cnt),
    .boundary    (boundary)
  );

  assign frame_end = boundary && (row_cnt == ROW_LAST);

  // Ties go to whoever did not win last; an idle cycle keeps the same preference.
  always_comb begin
    if (reqA_valid && !reqB_valid) begin
      grant = OWN_A;
    end else if (reqB_valid && !reqA_valid) begin
      grant = OWN_B;
    end else begin
      grant = (last_q == OWN_A) ? OWN_B : OWN_A;
    end
  end

  assign reqA_ready = (state_q == SH_EMPTY) && (grant == OWN_A) && !rst;
  assign reqB_ready = (state_q == SH_EMPTY) && (grant == OWN_B) && !rst;
  assign accept     = (reqA_ready && reqA_valid) || (reqB_ready && reqB_valid);

  always_comb begin
    state_d      = state_q;
    shadow_d     = shadow_q;
    shadow_own_d = shadow_own_q;
    matrix_d     = matrix_q;
    owner_d      = owner_q;
    last_d       = last_q;
    done_d       = 1'b0;
    case (state_q)
      SH_EMPTY: begin
        if (accept) begin
          state_d      = SH_FULL;
          shadow_d     = (grant == OWN_A) ? reqA_frame : reqB_frame;
          shadow_own_d = grant;
          last_d       = grant;
        end
      end
      SH_FULL: begin
        if (frame_end) begin
          state_d  = SH_EMPTY;
          matrix_d = shadow_q;
          owner_d  = shadow_own_q;
          done_d   = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= SH_EMPTY;
      shadow_q     <= '0;
      shadow_own_q <= OWN_A;
      matrix_q     <= '0;
      owner_q      <= OWN_A;
      last_q       <= OWN_B;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      shadow_q     <= shadow_d;
      shadow_own_q <= shadow_own_d;
      matrix_q     <= matrix_d;
      owner_q      <= owner_d;
      last_q       <= last_d;
      done_q       <= done_d;
    end
  end

  assign matrixOut = matrix_q;
  assign frameDone = done_q;
  assign ownerOut  = (owner_q == OWN_B);

endmodule

// File: tb/tb_led_frame_scheduler.sv
// Self-checking bench for led_frame_scheduler with TICK_DIV=4 (scan boundary every 32 cycles).
module tb_led_frame_scheduler;

  localparam int unsigned TD        = 4;
  localparam int          FRAME_CYC = TD * 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_valid, b_valid;
  logic [63:0] a_frame, b_frame;
  logic        a_ready, b_ready;
  logic [63:0] matrix_out;
  logic        pulse_out, done_out, owner_out;

  int n_checks = 0;
  int n_errors = 0;

  // Transaction-level model: cycle index since reset release, one-deep shadow slot.
  int          m_cyc;
  bit          m_full, m_sown, m_own, m_last, m_done, m_acc_a, m_acc_b;
  logic [63:0] m_shadow, m_disp;

  always #5 clk = ~clk;

  led_frame_scheduler #(.TICK_DIV(TD), .ROWS(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .reqA_valid  (a_valid),
    .reqA_frame  (a_frame),
    .reqA_ready  (a_ready),
    .reqB_valid  (b_valid),
    .reqB_frame  (b_frame),
    .reqB_ready  (b_ready),
    .matrixOut   (matrix_out),
    .timePulseOut(pulse_out),
    .frameDone   (done_out),
    .ownerOut    (owner_out)
  );

  function automatic bit exp_pulse(input int c);
    return (c != 0) && (c % TD == 0);
  endfunction

  task automatic model_reset();
    m_cyc = 0; m_full = 0; m_sown = 0; m_own = 0; m_last = 1; m_done = 0;
    m_shadow = '0; m_disp = '0;
  endtask

  task automatic reset_dut(input int n);
    rst = 1'b1; a_valid = 1'b0; b_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  // Advance one clock, applying the current inputs to the model.
  task automatic advance();
    bit bnd;
    m_acc_a = !m_full && a_valid && (!b_valid || m_last);
    m_acc_b = !m_full && b_valid && (!a_valid || !m_last);
    bnd = (m_cyc != 0) && (m_cyc % FRAME_CYC == 0);
    @(posedge clk);
    m_done = 0;
    if (m_full && bnd) begin
      m_disp = m_shadow; m_own = m_sown; m_done = 1; m_full = 0;
    end else if (m_acc_a) begin
      m_full = 1; m_shadow = a_frame; m_sown = 0; m_last = 0;
    end else if (m_acc_b) begin
      m_full = 1; m_shadow = b_frame; m_sown = 1; m_last = 1;
    end
    m_cyc++;
    #1;
  endtask

  task automatic run_to(input int c);
    while (m_cyc < c) advance();
  endtask

  task automatic test_reset();
    rst = 1'b1; a_valid = 1'b1; b_valid = 1'b1;
    a_frame = 64'h1111; b_frame = 64'h2222;
    repeat (3) begin
      @(posedge clk); #1;
      n_checks++;
      if (a_ready !== 1'b0 || b_ready !== 1'b0) begin
        n_errors++; $display("FAIL reset_ready: got A=%b B=%b required 0 0", a_ready, b_ready);
      end
    end
    a_valid = 1'b0; b_valid = 1'b0; rst = 1'b0;
    model_reset();
    n_checks++;
    if (matrix_out !== 64'h0 || owner_out !== 1'b0 || done_out !== 1'b0 || pulse_out !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_state: got m=%h own=%b done=%b pulse=%b required 0 0 0 0",
               matrix_out, owner_out, done_out, pulse_out);
    end
    repeat (13) begin
      advance();
      n_checks++;
      if (pulse_out !== exp_pulse(m_cyc)) begin
        n_errors++; $display("FAIL tick c=%0d: got %b required %b", m_cyc, pulse_out, exp_pulse(m_cyc));
      end
    end
  endtask

  task automatic test_single();
    reset_dut(2);
    advance();
    a_valid = 1'b1; a_frame = 64'hAA55AA55AA55AA55;
    #1;
    n_checks++;
    if (a_ready !== 1'b1) begin
      n_errors++; $display("FAIL single_ready: got %b required 1", a_ready);
    end
    advance();
    a_valid = 1'b0;
    run_to(32);
    n_checks++;
    if (matrix_out !== 64'h0 || done_out !== 1'b0) begin
      n_errors++; $display("FAIL single_pre: got m=%h done=%b required 0 0", matrix_out, done_out);
    end
    advance();
    n_checks++;
    if (matrix_out !== 64'hAA55AA55AA55AA55 || done_out !== 1'b1 || owner_out !== 1'b0) begin
      n_errors++;
      $display("FAIL single_swap: got m=%h done=%b own=%b required aa55aa55aa55aa55 1 0",
               matrix_out, done_out, owner_out);
    end
    advance();
    n_checks++;
    if (done_out !== 1'b0) begin
      n_errors++; $display("FAIL single_done_width: got %b required 0", done_out);
    end
  endtask

  task automatic test_tie();
    reset_dut(2);
    a_valid = 1'b1; a_frame = 64'h1; b_valid = 1'b1; b_frame = 64'h2;
    #1;
    n_checks++;
    if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
      n_errors++; $display("FAIL tie_first: got A=%b B=%b required 1 0", a_ready, b_ready);
    end
    advance();
    a_valid = 1'b0;
    while (m_cyc <= 32) begin
      n_checks++;
      if (b_ready !== 1'b0) begin
        n_errors++; $display("FAIL tie_hold c=%0d: got readyB=%b required 0", m_cyc, b_ready);
      end
      advance();
    end
    n_checks++;
    if (matrix_out !== 64'h1 || owner_out !== 1'b0 || done_out !== 1'b1 || b_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL tie_swapA: got m=%h own=%b done=%b readyB=%b required 1 0 1 1",
               matrix_out, owner_out, done_out, b_ready);
    end
    advance();
    b_valid = 1'b0;
    run_to(65);
    n_checks++;
    if (matrix_out !== 64'h2 || owner_out !== 1'b1 || done_out !== 1'b1) begin
      n_errors++;
      $display("FAIL tie_swapB: got m=%h own=%b done=%b required 2 1 1", matrix_out, owner_out, done_out);
    end
  endtask

  task automatic test_backpressure();
    reset_dut(2);
    a_valid = 1'b1; a_frame = 64'h1234;
    advance();
    a_valid = 1'b0;
    run_to(5);
    b_valid = 1'b1; b_frame = 64'hFF;
    #1;
    repeat (20) begin
      n_checks++;
      if (b_ready !== 1'b0 || matrix_out !== 64'h0) begin
        n_errors++;
        $display("FAIL bp_hold c=%0d: got readyB=%b m=%h required 0 0", m_cyc, b_ready, matrix_out);
      end
      advance();
    end
    run_to(33);
    n_checks++;
    if (matrix_out !== 64'h1234 || b_ready !== 1'b1) begin
      n_errors++; $display("FAIL bp_swap: got m=%h readyB=%b required 1234 1", matrix_out, b_ready);
    end
    advance();
    b_valid = 1'b0;
    run_to(65);
    n_checks++;
    if (matrix_out !== 64'hFF || owner_out !== 1'b1) begin
      n_errors++; $display("FAIL bp_kept: got m=%h own=%b required ff 1", matrix_out, owner_out);
    end
  endtask

  task automatic test_collision();
    reset_dut(2);
    run_to(32);
    a_valid = 1'b1; a_frame = 64'hC0FFEE;
    #1;
    n_checks++;
    if (a_ready !== 1'b1 || pulse_out !== 1'b1) begin
      n_errors++; $display("FAIL coll_ready: got ready=%b pulse=%b required 1 1", a_ready, pulse_out);
    end
    advance();
    a_valid = 1'b0;
    while (m_cyc <= 64) begin
      n_checks++;
      if (done_out !== 1'b0 || matrix_out !== 64'h0) begin
        n_errors++;
        $display("FAIL coll_wait c=%0d: got done=%b m=%h required 0 0", m_cyc, done_out, matrix_out);
      end
      advance();
    end
    n_checks++;
    if (matrix_out !== 64'hC0FFEE || done_out !== 1'b1) begin
      n_errors++; $display("FAIL coll_swap: got m=%h done=%b required c0ffee 1", matrix_out, done_out);
    end
  endtask

  task automatic test_midreset();
    reset_dut(2);
    a_valid = 1'b1; a_frame = 64'h5;
    advance();
    a_valid = 1'b0;
    run_to(33);
    a_valid = 1'b1; a_frame = 64'hDEAD;
    #1;
    n_checks++;
    if (matrix_out !== 64'h5 || a_ready !== 1'b1) begin
      n_errors++; $display("FAIL mid_pre: got m=%h ready=%b required 5 1", matrix_out, a_ready);
    end
    advance();
    a_valid = 1'b0;
    run_to(40);
    reset_dut(2);
    n_checks++;
    if (matrix_out !== 64'h0 || owner_out !== 1'b0 || done_out !== 1'b0 || pulse_out !== 1'b0) begin
      n_errors++;
      $display("FAIL mid_reset: got m=%h own=%b done=%b pulse=%b required 0 0 0 0",
               matrix_out, owner_out, done_out, pulse_out);
    end
    repeat (TD) begin
      advance();
      n_checks++;
      if (pulse_out !== exp_pulse(m_cyc)) begin
        n_errors++; $display("FAIL mid_tick c=%0d: got %b required %b", m_cyc, pulse_out, exp_pulse(m_cyc));
      end
    end
    run_to(34);
    n_checks++;
    if (matrix_out !== 64'h0 || done_out !== 1'b0) begin
      n_errors++; $display("FAIL mid_discard: got m=%h done=%b required 0 0", matrix_out, done_out);
    end
  endtask

  task automatic test_random();
    bit exp_ra, exp_rb;
    reset_dut(2);
    repeat (1500) begin
      n_checks++;
      if (matrix_out !== m_disp || owner_out !== m_own || done_out !== m_done ||
          pulse_out !== exp_pulse(m_cyc)) begin
        n_errors++;
        $display("FAIL rand_out c=%0d: got m=%h own=%b done=%b pulse=%b required %h %b %b %b",
                 m_cyc, matrix_out, owner_out, done_out, pulse_out,
                 m_disp, m_own, m_done, exp_pulse(m_cyc));
      end
      if (!a_valid && $urandom_range(0, 3) == 0) begin
        a_valid = 1'b1; a_frame = {$urandom, $urandom};
      end
      if (!b_valid && $urandom_range(0, 3) == 0) begin
        b_valid = 1'b1; b_frame = {$urandom, $urandom};
      end
      #1;
      exp_ra = !m_full && (!b_valid || m_last);
      exp_rb = !m_full && (!a_valid || !m_last);
      n_checks++;
      if ((a_ready && b_ready) || (a_valid && a_ready !== exp_ra) || (b_valid && b_ready !== exp_rb)) begin
        n_errors++;
        $display("FAIL rand_ready c=%0d: got A=%b B=%b required A=%b B=%b (valid %b %b)",
                 m_cyc, a_ready, b_ready, exp_ra, exp_rb, a_valid, b_valid);
      end
      advance();
      if (m_acc_a) a_valid = 1'b0;
      if (m_acc_b) b_valid = 1'b0;
    end
  endtask

  initial begin
    a_valid = 1'b0; b_valid = 1'b0; a_frame = '0; b_frame = '0;
    test_reset();
    test_single();
    test_tie();
    test_backpressure();
    test_collision();
    test_midreset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/led_frame_scheduler.md
Name: led_frame_scheduler

Overview:
- Sits upstream of the 8x8 LED matrix row-scan controller.
- Shares the single 64-bit display frame between two frame producers (A: game/logic, B: message/scroll) using a round-robin valid/ready arbiter.
- Double-buffers the winning frame and swaps it onto the display only at a full 8-row scan boundary, so no frame ever tears mid-scan.
- Generates the row-advance time pulse that the scan controller consumes.

Parameters:
- TICK_DIV, 1000, clock cycles per row-advance pulse; legal range ≥2.
- ROWS, 8, rows per scan frame; fixed at 8 for the 8x8 matrix.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- reqA_valid  in  1  requester A offers a frame
- reqA_frame  in  64  A frame; row 1 = [63:56] … row 8 = [7:0]
- reqA_ready  out  1  A frame accepted this cycle if reqA_valid
- reqB_valid  in  1  requester B offers a frame
- reqB_frame  in  64  B frame; same row packing as A
- reqB_ready  out  1  B frame accepted this cycle if reqB_valid
- matrixOut  out  64  active frame driven to the scan controller's matrixIn
- timePulseOut  out  1  one-cycle row-advance pulse
- frameDone  out  1  one-cycle pulse, active frame just replaced
- ownerOut  out  1  source of active frame: 0 = A, 1 = B

Behaviour:
Reset (rst=1 at posedge):
- matrixOut=0, timePulseOut=0, frameDone=0, ownerOut=0.
- Prescaler=0, rowCnt=0.
- Shadow buffer empty; lastGrant=B, so A wins the first tie.
- Any pending shadow frame is discarded.
- readyA/readyB = 0 while rst is high.

Prescaler:
- Counts 0..TICK_DIV-1, then wraps.
- timePulseOut is registered and high for exactly 1 cycle when prescaler == TICK_DIV-1, giving a period of TICK_DIV cycles.
- First pulse occurs TICK_DIV cycles after rst deasserts.

Row counter:
- 3-bit; increments on each pulse and wraps 7→0.
- A boundary is the pulse cycle with rowCnt==7.

State machine (shadow buffer):
- EMPTY: accepting requests.
- FULL: holding one frame, waiting for a boundary.
- EMPTY→FULL on a handshake: shadow <= granted frame, shadowOwner <= granted id, lastGrant <= granted id.
- FULL→EMPTY on a boundary:
  - next cycle matrixOut <= shadow and ownerOut <= shadowOwner;
  - frameDone pulses in that same next cycle.
- A boundary in EMPTY changes nothing; matrixOut holds its value and frameDone stays 0.
- A handshake in the same cycle as a boundary while EMPTY: the frame goes to FULL and waits for the next boundary (8·TICK_DIV cycles later).

Arbitration (combinational from registered state):
- Only A valid → grant A; only B valid → grant B.
- Both valid → grant the one ≠ lastGrant.
- readyX = (state==EMPTY) & grant==X & !rst.
- At most one ready high per cycle. ready may be high while the corresponding valid is low (no accept occurs).
- Requester rule: frame stable and valid held until ready; the scheduler does not check this.
- FULL: both ready low. New requests are back-pressured, never dropped or overwritten.

Latency:
- Accept → display is at minimum 1 cycle after the next boundary and at most 8·TICK_DIV+1 cycles.

Decomposition:
- Shared package led_pkg:
  - LED_ROWS=8, LED_COLS=8, FRAME_W=64;
  - owner enum {OWN_A=0, OWN_B=1};
  - shadow-state enum {SH_EMPTY, SH_FULL};
  - row slice constants.
- Sub-module led_tick_gen (parameter TICK_DIV): prescaler + rowCnt.
  - Outputs: timePulseOut, rowCnt, boundary.
  - Reusable by other display blocks.
- Arbiter and shadow buffer stay in the top module.

Test Plan (TICK_DIV=4, so pulses at cycles 4, 8, …; boundary every 32 cycles):
- Reset/tick: hold rst 3 cycles, release → matrixOut=0, ownerOut=0, frameDone=0; timePulseOut high exactly at post-reset cycles 4, 8, 12, …, each 1 cycle wide.
- Single request: A offers 64'hAA55AA55AA55AA55 at cycle 1 → readyA=1 at cycle 1; matrixOut shows the value and frameDone=1 one cycle after the pulse at cycle 32; ownerOut=0.
- Tie round-robin: A=64'h1, B=64'h2 both valid from reset → A accepted first; B waits with readyB=0 while FULL, then is accepted the cycle after A swaps in; display shows 1 then 2; ownerOut 0 then 1.
- Back-pressure: with shadow FULL, present B=64'hFF for 20 cycles → readyB stays 0; matrixOut unchanged until the boundary; no frame lost.
- Boundary collision: A handshake in the exact boundary cycle while EMPTY → matrixOut unchanged and no frameDone at that boundary; swap happens at the next boundary (+32 cycles).
- Mid-operation reset: assert rst while FULL with 64'hDEAD → shadow discarded; after release matrixOut=0, counters restart, and the next pulse comes TICK_DIV cycles later.
